imem_loader: RTL

- Writer side of the instruction memory interface.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written into the word-addressed instruction store through a single-cycle write strobe.
- Holds the core in reset until a load completes, and reports a running 32-bit checksum of all words written.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 121 ++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Handshake and memory-write bundle between the byte-stream source,
// the instruction-memory loader and the instruction store.
interface imem_loader_if #(
    parameter int LEN_W = 17
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             busy;
    logic             done;
    logic             cpu_hold;
    logic [31:0]      checksum;

    modport master (
        output start, len, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold, checksum
    );

    modport slave (
        input  start, len, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold, checksum
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit
// words, writes them to the word-addressed store and keeps the core in reset.
module imem_loader #(
    parameter int          LEN_W     = 17,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic       clk,
    input  logic       reset,
    imem_loader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count;
    logic [1:0]       idx;
    logic [23:0]      wbuf;
    logic [LEN_W-1:0] count_nxt;

    function automatic logic [31:0] word_addr(input logic [LEN_W-1:0] n);
        return BASE_ADDR + 32'(n);
    endfunction

    function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] w);
        return acc + w;
    endfunction

    always_comb begin
        count_nxt = count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            len_q         <= '0;
            count         <= '0;
            idx           <= 2'd0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.cpu_hold  <= 1'b1;
            bus.checksum  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.checksum <= 32'h0;
                        bus.cpu_hold <= 1'b1;
                        if (bus.len != '0) begin
                            len_q        <= bus.len;
                            count        <= '0;
                            idx          <= 2'd0;
                            bus.in_ready <= 1'b1;
                            bus.busy     <= 1'b1;
                            state        <= RECV;
                        end else begin
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                RECV: begin
                    // in_ready is high throughout RECV, so in_valid alone marks a handshake
                    if (bus.in_valid) begin
                        if (idx == 2'd3) begin
                            idx           <= 2'd0;
                            bus.in_ready  <= 1'b0;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= word_addr(count);
                            bus.mem_wdata <= {bus.in_data, wbuf};
                            state         <= WRITE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    bus.mem_we   <= 1'b0;
                    bus.checksum <= csum_add(bus.checksum, bus.mem_wdata);
                    count        <= count_nxt;
                    if (count_nxt == len_q) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        bus.in_ready <= 1'b1;
                        state        <= RECV;
                    end
                end
                DONE: begin
                    bus.done     <= 1'b0;
                    bus.cpu_hold <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte buffer is pure data: a stale partial word is harmless because idx restarts at 0.
    always_ff @(posedge clk) begin
        if (state == RECV && bus.in_valid) begin
            case (idx)
                2'd0:    wbuf[7:0]   <= bus.in_data;
                2'd1:    wbuf[15:8]  <= bus.in_data;
                2'd2:    wbuf[23:16] <= bus.in_data;
                default: wbuf        <= wbuf;
            endcase
        end
    end

endmodule
